// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multi-cycle control FSM for the 4-bit-opcode accumulator ISA. One
// instruction is accepted per handshake and sequenced through
// DECODE -> EXEC -> (MEM) -> (WB) before returning to IDLE.
//
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode (opcode >= 16, only possible when
//               OPCODE_W > 4) parks the unit in TRAP with trap = 1 until reset.
//   undefined : an illegal opcode runs as a NOP (pc_inc in EXEC), trap = 0.
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready are both high. instr_ready depends only on the
// state register (high only in IDLE), never on instr_valid.
//
// Opcode map (low four opcode bits):
//   0 move  1 add  2 and  3 not  4 nor  5 slt  6 sll  7 srl
//   8 addi  9 jal  A lw   B sw   C beq  D bne  E j    F li
//
// Output timing: everything is decoded from the state and instruction
// registers. The only places an input reaches an output in the same cycle
// are the PC strobes of a branch in EXEC (qualified by alu_zero) and the
// pc_inc of a store in its acknowledge cycle (qualified by mem_ack), so
// that the PC update lands in the instruction's final cycle.
//
// dbg_state exposes the raw state register for checkers.

module multicycle_control_unit #(
    parameter int INSTR_W  = 8,
    parameter int OPCODE_W = 4,
    parameter int RADDR_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               instr_ready,
    input  logic               alu_zero,
    input  logic               mem_ack,
    output logic [RADDR_W-1:0] reg_addr_0,
    output logic [RADDR_W-1:0] reg_addr_1,
    output logic [RADDR_W-1:0] reg_addr_w,
    output logic               reg_w_en,
    output logic [1:0]         sel_w_source,
    output logic               mem_r_en,
    output logic               mem_w_en,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               busy,
    output logic               trap,
    output logic [2:0]         dbg_state
);

    // ------------------------------------------------------------------
    // Opcodes and write-source encodings
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_MOVE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_J    = 4'hE;
    localparam logic [3:0] OP_LI   = 4'hF;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC1 = 2'b10;
    localparam logic [1:0] SRC_IMM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef CU_ILLEGAL_TRAP_EN
        ,
        ST_TRAP   = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [OPCODE_W-1:0] opcode;
    logic [3:0]          op_lo;
    logic                op_illegal;
    logic [RADDR_W-1:0]  field_0;
    logic [RADDR_W-1:0]  field_1;

    assign opcode  = ir_q[INSTR_W-1 -: OPCODE_W];
    assign op_lo   = opcode[3:0];
    assign field_0 = ir_q[RADDR_W-1:0];
    assign field_1 = ir_q[2*RADDR_W-1:RADDR_W];

    // Only a wider opcode field can encode values outside the 16 legal ops.
    generate
        if (OPCODE_W > 4) begin : g_wide_opcode
            assign op_illegal = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow_opcode
            assign op_illegal = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Instruction decode (from IR only)
    // ------------------------------------------------------------------
    logic               dec_write;   // instruction ends with a WB cycle
    logic               dec_mem_rd;  // lw
    logic               dec_mem_wr;  // sw
    logic               dec_jump;    // unconditional PC load (j, jal)
    logic               dec_beq;
    logic               dec_bne;
    logic [RADDR_W-1:0] dec_waddr;
    logic [1:0]         dec_sel;

    // Classify the latched opcode; illegal opcodes decode to "do nothing".
    always_comb begin
        dec_write  = 1'b0;
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_jump   = 1'b0;
        dec_beq    = 1'b0;
        dec_bne    = 1'b0;
        dec_waddr  = '0;
        dec_sel    = SRC_ALU;
        if (!op_illegal) begin
            case (op_lo)
                OP_MOVE, OP_NOT, OP_SLL, OP_SRL, OP_ADDI: begin
                    dec_write = 1'b1;
                    dec_waddr = field_1;
                end
                OP_LI: begin
                    dec_write = 1'b1;
                    dec_waddr = field_1;
                    dec_sel   = SRC_IMM;
                end
                OP_ADD, OP_AND, OP_NOR, OP_SLT: begin
                    dec_write = 1'b1;
                end
                OP_LW: begin
                    dec_write  = 1'b1;
                    dec_mem_rd = 1'b1;
                    dec_sel    = SRC_MEM;
                end
                OP_JAL: begin
                    // Link register is the highest-numbered register.
                    dec_write = 1'b1;
                    dec_jump  = 1'b1;
                    dec_waddr = '1;
                    dec_sel   = SRC_PC1;
                end
                OP_SW:   dec_mem_wr = 1'b1;
                OP_J:    dec_jump   = 1'b1;
                OP_BEQ:  dec_beq    = 1'b1;
                OP_BNE:  dec_bne    = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and instruction registers
    // ------------------------------------------------------------------
    // Async reset drops any instruction in flight and clears IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and IR capture on the handshake.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (op_illegal) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_IDLE;
`endif
                end else if (dec_mem_rd || dec_mem_wr) begin
                    state_d = ST_MEM;
                end else if (dec_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = dec_mem_rd ? ST_WB : ST_IDLE;
                end
            end
            ST_WB: state_d = ST_IDLE;
`ifdef CU_ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_idle;
    assign in_idle = (state_q == ST_IDLE);

    assign instr_ready = in_idle;
    assign busy        = !in_idle;
    assign dbg_state   = state_q;
    assign reg_addr_0  = field_0;
    assign reg_addr_1  = field_1;

    // Datapath strobes and PC control decoded from state (plus the branch
    // flag / memory ack in the instruction's final cycle).
    always_comb begin
        reg_addr_w   = '0;
        sel_w_source = SRC_ALU;
        reg_w_en     = 1'b0;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        trap         = 1'b0;

        // Write address/source are held for the whole instruction.
        if (!in_idle) begin
            reg_addr_w   = dec_waddr;
            sel_w_source = dec_sel;
        end

        case (state_q)
            ST_EXEC: begin
                if (op_illegal) begin
`ifndef CU_ILLEGAL_TRAP_EN
                    pc_inc = 1'b1;
`endif
                end else if (!dec_write && !dec_mem_rd && !dec_mem_wr) begin
                    // Control-flow ops finish here.
                    if (dec_jump) begin
                        pc_load = 1'b1;
                    end else if (dec_beq) begin
                        pc_load = alu_zero;
                        pc_inc  = !alu_zero;
                    end else if (dec_bne) begin
                        pc_load = !alu_zero;
                        pc_inc  = alu_zero;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                mem_r_en = dec_mem_rd;
                mem_w_en = dec_mem_wr;
                // A store completes in its ack cycle.
                if (mem_ack && dec_mem_wr) begin
                    pc_inc = 1'b1;
                end
            end
            ST_WB: begin
                // jal writes the link (old PC+1) and loads the PC together.
                reg_w_en = 1'b1;
                if (dec_jump) begin
                    pc_load = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
`ifdef CU_ILLEGAL_TRAP_EN
            ST_TRAP: trap = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
